// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter: op codes, slot state, requester ids.
package alu_pkg;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_NOT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; results wrap mod 2^W, shifts are by one with zero fill.
module alu
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   s,
  output logic [W-1:0] out
);
  always_comb begin
    out = '0;
    case (s)
      ALU_ADD: out = a + b;
      ALU_SUB: out = a - b;
      ALU_AND: out = a & b;
      ALU_OR:  out = a | b;
      ALU_XOR: out = a ^ b;
      ALU_NOT: out = ~a;
      ALU_SHL: out = {a[W-2:0], 1'b0};
      ALU_SHR: out = {1'b0, a[W-1:1]};
      default: out = '0;
    endcase
  end
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU between two requesters with a single registered result slot.
// Optional ALU_FLAGS_EN adds registered rsp_zero / rsp_carry outputs.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic [2:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  input  logic [2:0]   req1_op,
  output logic         rsp0_valid,
  input  logic         rsp0_ready,
  output logic         rsp1_valid,
  input  logic         rsp1_ready,
  output logic [W-1:0] rsp_data
`ifdef ALU_FLAGS_EN
  ,
  output logic         rsp_zero,
  output logic         rsp_carry
`endif
);
  state_t       r_state, w_state_nxt;
  logic         r_owner, r_last;
  logic [W-1:0] r_data;
  logic         w_owner_rdy, w_free, w_g0, w_g1, w_acc;
  logic [W-1:0] w_a, w_b, w_alu;
  logic [2:0]   w_op;

  assign rsp0_valid  = (r_state == HOLD) && (r_owner == REQ0);
  assign rsp1_valid  = (r_state == HOLD) && (r_owner == REQ1);
  assign w_owner_rdy = (r_owner == REQ1) ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Ready is gated by rst_n so nothing is offered while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    w_free      = (r_state == IDLE) || w_owner_rdy;
    w_g0        = req0_valid && (!req1_valid || (r_last == REQ1));
    w_g1        = req1_valid && (!req0_valid || (r_last == REQ0));
    req0_ready  = rst_n && w_free && w_g0;
    req1_ready  = rst_n && w_free && w_g1;
    w_acc       = req0_ready || req1_ready;
    case (r_state)
      IDLE:    if (w_acc) w_state_nxt = HOLD;
      HOLD:    if (w_owner_rdy && !w_acc) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_a  = w_g1 ? req1_a  : req0_a;
  assign w_b  = w_g1 ? req1_b  : req0_b;
  assign w_op = w_g1 ? req1_op : req0_op;

  alu #(.W(W)) u_alu (
    .a   (w_a),
    .b   (w_b),
    .s   (w_op),
    .out (w_alu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_owner <= REQ0;
      r_last  <= REQ1;
    end else if (w_acc) begin
      r_data  <= w_alu;
      r_owner <= w_g1;
      r_last  <= w_g1;
    end
  end

  assign rsp_data = r_data;

`ifdef ALU_FLAGS_EN
  logic [W:0] w_sum;
  logic       w_carry;
  logic       r_zero, r_carry;

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  always_comb begin
    w_carry = 1'b0;
    case (w_op)
      ALU_ADD: w_carry = w_sum[W];
      ALU_SUB: w_carry = (w_a < w_b);
      ALU_SHL: w_carry = w_a[W-1];
      ALU_SHR: w_carry = w_a[0];
      default: w_carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
    end else if (w_acc) begin
      r_zero  <= (w_alu == '0);
      r_carry <= w_carry;
    end
  end

  assign rsp_zero  = r_zero;
  assign rsp_carry = r_carry;
`endif
endmodule
